// File: rtl/ag32gbd_pkg.sv
// Shared types and sizes for the bank0 SRAM reader.
package ag32gbd_pkg;

   localparam int MAX_BURST    = 1024;
   localparam int SRAM_ADDR_W  = 12;
   localparam int BUF_OFFSET_W = $clog2(MAX_BURST);
   localparam int LEN_W        = $clog2(MAX_BURST) + 1;
   localparam int CNT_W        = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_ACCESS = 3'd2,
      ST_PUSH   = 3'd3,
      ST_NEXT   = 3'd4,
      ST_DONE   = 3'd5
   } rd_state_t;

endpackage

// File: rtl/ag32gbd_sync2.sv
// Two-flop synchronizer for a slow asynchronous level (cart bus clock); resets to 0.
module ag32gbd_sync2 (
   input  logic sys_clock,
   input  logic sys_resetn,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/ag32gbd_ram_read.sv
// Burst copy of bank0 SRAM bytes into the 10-bit transfer buffer.
// Optional AG32GBD_RAM_READ_CHECKSUM_EN adds an 8-bit running sum output (Checksum).
//
// state  | meaning
// IDLE   | waiting for Start, SRAM bus released
// SETUP  | bus owned, address and nCS valid, nOE high; waits setup time and cart_CLK high
// ACCESS | nOE low for ACCESS_CYCLES, data sampled on the last cycle
// PUSH   | nCS/nOE high, byte offered to buffer until acknowledged
// NEXT   | advance address/offset, decide next byte or finish
// DONE   | bus released, one-cycle Done pulse
module ag32gbd_ram_read
   import ag32gbd_pkg::*;
#(
   parameter int ACCESS_CYCLES = 3,
   parameter int SETUP_CYCLES  = 1
) (
   input  logic                    sys_clock,
   input  logic                    sys_resetn,
   input  logic                    cart_CLK,
   input  logic                    Start,
   input  logic [SRAM_ADDR_W-1:0]  StartAddr,
   input  logic [LEN_W-1:0]        Length,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Gbd_Reading_Ram,
   output logic [SRAM_ADDR_W-1:0]  Ram_Reading_Addr_Low,
   input  logic [7:0]              Ram_Reading_Data,
   output logic                    Ram_Reading_nCS,
   output logic                    Ram_Reading_nOE,
   output logic                    RequestWriteBuffer,
   output logic [BUF_OFFSET_W-1:0] WriteBufferOffset,
   output logic [7:0]              WriteBufferData,
   input  logic                    BufferWriteAck
`ifdef AG32GBD_RAM_READ_CHECKSUM_EN
   ,
   output logic [7:0]              Checksum
`endif
);

   localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES);
   localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'(ACCESS_CYCLES);

   rd_state_t         state;
   logic [LEN_W-1:0]  remaining;
   logic [CNT_W-1:0]  setup_cnt;
   logic [CNT_W-1:0]  access_cnt;
   logic              cart_clk_sync;

   ag32gbd_sync2 u_cart_clk_sync (
      .sys_clock  (sys_clock),
      .sys_resetn (sys_resetn),
      .async_in   (cart_CLK),
      .sync_out   (cart_clk_sync)
   );

   always_ff @(posedge sys_clock or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state                <= ST_IDLE;
         Busy                 <= 1'b0;
         Done                 <= 1'b0;
         Gbd_Reading_Ram      <= 1'b0;
         Ram_Reading_Addr_Low <= '0;
         Ram_Reading_nCS      <= 1'b1;
         Ram_Reading_nOE      <= 1'b1;
         RequestWriteBuffer   <= 1'b0;
         WriteBufferOffset    <= '0;
         WriteBufferData      <= '0;
         remaining            <= '0;
         setup_cnt            <= '0;
         access_cnt           <= '0;
`ifdef AG32GBD_RAM_READ_CHECKSUM_EN
         Checksum             <= '0;
`endif
      end else begin
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
`ifdef AG32GBD_RAM_READ_CHECKSUM_EN
                  Checksum <= '0;
`endif
                  if (Length != '0) begin
                     state                <= ST_SETUP;
                     Busy                 <= 1'b1;
                     Gbd_Reading_Ram      <= 1'b1;
                     Ram_Reading_Addr_Low <= StartAddr;
                     Ram_Reading_nCS      <= 1'b0;
                     remaining            <= Length;
                     WriteBufferOffset    <= '0;
                     setup_cnt            <= SETUP_LOAD;
                  end else begin
                     state <= ST_DONE;
                     Done  <= 1'b1;
                  end
               end
            end
            // SETUP always lasts at least one cycle so nOE never falls with the address.
            ST_SETUP: begin
               if (setup_cnt > CNT_W'(1)) begin
                  setup_cnt <= setup_cnt - CNT_W'(1);
               end else if (cart_clk_sync) begin
                  state           <= ST_ACCESS;
                  Ram_Reading_nOE <= 1'b0;
                  access_cnt      <= ACCESS_LOAD;
               end
            end
            ST_ACCESS: begin
               if (access_cnt > CNT_W'(1)) begin
                  access_cnt <= access_cnt - CNT_W'(1);
               end else begin
                  state              <= ST_PUSH;
                  WriteBufferData    <= Ram_Reading_Data;
                  Ram_Reading_nOE    <= 1'b1;
                  Ram_Reading_nCS    <= 1'b1;
                  RequestWriteBuffer <= 1'b1;
               end
            end
            ST_PUSH: begin
               if (BufferWriteAck) begin
                  state              <= ST_NEXT;
                  RequestWriteBuffer <= 1'b0;
`ifdef AG32GBD_RAM_READ_CHECKSUM_EN
                  Checksum <= Checksum + WriteBufferData;
`endif
               end
            end
            // Offset only advances when another byte follows, so it never wraps in a burst.
            ST_NEXT: begin
               remaining <= remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  state           <= ST_DONE;
                  Busy            <= 1'b0;
                  Gbd_Reading_Ram <= 1'b0;
                  Done            <= 1'b1;
               end else begin
                  state                <= ST_SETUP;
                  Ram_Reading_Addr_Low <= Ram_Reading_Addr_Low + SRAM_ADDR_W'(1);
                  WriteBufferOffset    <= WriteBufferOffset + BUF_OFFSET_W'(1);
                  Ram_Reading_nCS      <= 1'b0;
                  setup_cnt            <= SETUP_LOAD;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
